// File: rtl/cam_timing_gen.sv
// cam_timing_gen: OV-style camera stimulus generator (pclk, vsync, href, 8-bit data)
// with configurable frame geometry, bytes per pixel, pclk divide, frame count and
// data pattern. It drives the ball detector's camera inputs.
//
// Ports:
//   inclk      system clock
//   res_n      asynchronous active-low reset
//   enable     start / continue generation
//   mode       0 byte ramp, 1 constant, 2 colour bars, 3 line index
//   frames     frames to emit, 0 = continuous
//   pclk       pixel clock, toggles every PCLK_DIV inclk cycles
//   vsync      frame sync, active high
//   href       line valid, active high
//   data       pixel byte, 0 outside href
//   frame_done one-inclk pulse at the end of each frame
//   busy       high from frame start until return to idle
//
// Optional feature, macro CAM_GEN_SHORTLINE_EN:
//   inj_short  rising edge arms a one-shot that shortens the next line by one pixel
//   short_done one-inclk pulse when the shortened href ends
//
// State    | meaning
// S_IDLE   | outputs low, waiting for enable
// S_VSYNC  | vsync high for V_SYNC lines
// S_VBACK  | V_BACK lines between vsync fall and first href
// S_ACTIVE | V_ACTIVE lines of href + blanking
// S_VFRONT | V_FRONT lines after last active line
module cam_timing_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_BLANK   = 144,
    parameter int          BPP       = 2,
    parameter int          V_SYNC    = 1,
    parameter int          V_BACK    = 3,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FRONT   = 10,
    parameter int          PCLK_DIV  = 16,
    parameter logic [7:0]  CONST_VAL = 8'h55
) (
    input  logic       inclk,
    input  logic       res_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] frames,
`ifdef CAM_GEN_SHORTLINE_EN
    input  logic       inj_short,
    output logic       short_done,
`endif
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic       frame_done,
    output logic       busy
);

    localparam int LINE     = (H_ACTIVE + H_BLANK) * BPP;
    localparam int ACT_FULL = H_ACTIVE * BPP;
    localparam int VMAX_A   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int VMAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX     = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
    localparam int HW       = $clog2(LINE + 1);
    localparam int VW       = $clog2(VMAX + 1);
    localparam int DW       = $clog2(PCLK_DIV + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(LINE - 1);
    localparam logic [HW-1:0] ACT_FULL_W = HW'(ACT_FULL);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] VB_LAST    = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST    = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST    = VW'(V_FRONT - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(PCLK_DIV - 1);
`ifdef CAM_GEN_SHORTLINE_EN
    localparam logic [HW-1:0] ACT_SHORT_W = HW'((H_ACTIVE - 1) * BPP);
`endif

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] ln_q, ln_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    frames_q, frames_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    data_q, data_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;

    logic          fall;
    logic          line_end;
    logic [HW-1:0] h_inc;
    logic [VW-1:0] ln_inc;
    logic [HW-1:0] act_len;

`ifdef CAM_GEN_SHORTLINE_EN
    logic [2:0] inj_sync_q, inj_sync_d;
    logic       armed_q, armed_d;
    logic       short_cur_q, short_cur_d;
    logic       short_done_q, short_done_d;
`endif

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        pclk_d       = pclk_q;
        h_d          = h_q;
        ln_d         = ln_q;
        fcnt_d       = fcnt_q;
        mode_d       = mode_q;
        frames_d     = frames_q;
        vsync_d      = vsync_q;
        href_d       = href_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        act_len      = ACT_FULL_W;
        line_end     = (h_q == H_LAST);
        h_inc        = line_end ? '0 : h_q + 1'b1;
        ln_inc       = line_end ? ln_q + 1'b1 : ln_q;
        fall         = (div_q == DIV_LAST) && pclk_q;
`ifdef CAM_GEN_SHORTLINE_EN
        inj_sync_d   = {inj_sync_q[1:0], inj_short};
        armed_d      = armed_q;
        short_cur_d  = short_cur_q;
        short_done_d = 1'b0;
`endif

        if (div_q == DIV_LAST) begin
            div_d  = '0;
            pclk_d = ~pclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d  = S_VSYNC;
                        h_d      = '0;
                        ln_d     = '0;
                        fcnt_d   = '0;
                        mode_d   = mode;
                        frames_d = frames;
                        busy_d   = 1'b1;
                    end
                end
                S_VSYNC: begin
                    h_d  = h_inc;
                    ln_d = ln_inc;
                    if (line_end && ln_q == VS_LAST) begin
                        state_d = S_VBACK;
                        ln_d    = '0;
                    end
                end
                S_VBACK: begin
                    h_d  = h_inc;
                    ln_d = ln_inc;
                    if (line_end && ln_q == VB_LAST) begin
                        state_d = S_ACTIVE;
                        ln_d    = '0;
                    end
                end
                S_ACTIVE: begin
                    h_d  = h_inc;
                    ln_d = ln_inc;
                    if (line_end && ln_q == VA_LAST) begin
                        state_d = S_VFRONT;
                        ln_d    = '0;
                    end
                end
                S_VFRONT: begin
                    h_d  = h_inc;
                    ln_d = ln_inc;
                    if (line_end && ln_q == VF_LAST) begin
                        frame_done_d = 1'b1;
                        fcnt_d       = fcnt_q + 8'd1;
                        ln_d         = '0;
                        // A dropped enable lets the running frame finish, then stops.
                        if ((frames_q != 8'd0 && fcnt_d == frames_q) || !enable) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d  = S_VSYNC;
                            mode_d   = mode;
                            frames_d = frames;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase

`ifdef CAM_GEN_SHORTLINE_EN
            // The one-shot is consumed by the line that starts next; the flag
            // then holds for that whole line so href and blanking stay consistent.
            if (state_d == S_ACTIVE && h_d == '0) begin
                short_cur_d = armed_q;
                armed_d     = 1'b0;
            end else if (state_d != S_ACTIVE) begin
                short_cur_d = 1'b0;
            end
            if (short_cur_d) begin
                act_len = ACT_SHORT_W;
            end
            if (short_cur_q && state_q == S_ACTIVE && h_d == ACT_SHORT_W) begin
                short_done_d = 1'b1;
            end
`endif

            vsync_d = (state_d == S_VSYNC);
            href_d  = (state_d == S_ACTIVE) && (h_d < act_len);
            data_d  = 8'h00;
            if (href_d) begin
                // h_d restarts at 0 on every href rise, so it doubles as the byte counter.
                case (mode_d)
                    2'd0:    data_d = 8'(h_d);
                    2'd1:    data_d = CONST_VAL;
                    2'd2:    data_d = 8'(((32'(h_d) / BPP) * 8 / H_ACTIVE) * 36);
                    default: data_d = 8'(ln_d);
                endcase
            end
        end

`ifdef CAM_GEN_SHORTLINE_EN
        if (inj_sync_q[1] && !inj_sync_q[2]) begin
            armed_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            pclk_q       <= 1'b1;
            h_q          <= '0;
            ln_q         <= '0;
            fcnt_q       <= '0;
            mode_q       <= '0;
            frames_q     <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CAM_GEN_SHORTLINE_EN
            inj_sync_q   <= '0;
            armed_q      <= 1'b0;
            short_cur_q  <= 1'b0;
            short_done_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            pclk_q       <= pclk_d;
            h_q          <= h_d;
            ln_q         <= ln_d;
            fcnt_q       <= fcnt_d;
            mode_q       <= mode_d;
            frames_q     <= frames_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef CAM_GEN_SHORTLINE_EN
            inj_sync_q   <= inj_sync_d;
            armed_q      <= armed_d;
            short_cur_q  <= short_cur_d;
            short_done_q <= short_done_d;
`endif
        end
    end

    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
`ifdef CAM_GEN_SHORTLINE_EN
    assign short_done = short_done_q;
`endif

endmodule

// File: doc/cam_timing_gen.md
Name: cam_timing_gen

Overview:
- Synthesizable, parametrised camera-interface stimulus generator, OV-style: pclk, vsync, href, 8-bit data.
- Drives the ball detector's camera inputs in simulation and in on-board loopback.
- Generalises the fixed-geometry generator to configurable resolution, blanking, bytes per pixel, pclk divide, frame count and pattern mode.
- Sits beside the detector top; its outputs connect to the detector's camera inputs (ahref, avsync, apclk, adata).

Parameters:
H_ACTIVE, 640, active pixels per line
H_BLANK, 144, blank pixels per line
BPP, 2, bytes per pixel (1..4)
V_SYNC, 1, vsync-high duration in lines
V_BACK, 3, lines between vsync fall and first href
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, lines after last active line before next vsync
PCLK_DIV, 16, inclk cycles per pclk half-period (>=1)
CONST_VAL, 8'h55, data byte for mode 1

Ports:
inclk  in  1  system clock
res_n  in  1  asynchronous active-low reset
enable  in  1  start/continue generation
mode  in  2  0 byte ramp, 1 constant, 2 colour bars, 3 line index
frames  in  8  frames to emit; 0 = continuous
pclk  out  1  pixel clock
vsync  out  1  frame sync, active high
href  out  1  line valid, active high
data  out  8  pixel byte
frame_done  out  1  one-inclk pulse at end of each frame's V_FRONT
busy  out  1  high from frame start until return to IDLE

Behaviour:
Clock and reset:
- One clock (inclk); reset is asynchronous and active-low (res_n).
- Reset values: pclk=1, vsync=0, href=0, data=0, frame_done=0, busy=0, FSM=IDLE, all counters 0.

pclk and timing base:
- pclk toggles every PCLK_DIV inclk cycles; it runs continuously after reset, including in IDLE.
- "Fall tick": the inclk cycle in which pclk goes 1->0.
- vsync, href and data change only on fall ticks; the receiver samples on the pclk rising edge.
- A line is L = (H_ACTIVE+H_BLANK)*BPP pclk periods. All vertical durations are counted in whole lines of fall ticks.

FSM (all transitions on fall ticks):
- IDLE: outputs low. If enable=1: latch mode and frames, busy=1, vsync=1, go to VSYNC.
- VSYNC: V_SYNC*L ticks, then vsync=0, go to VBACK.
- VBACK: V_BACK*L ticks, then go to ACTIVE.
- ACTIVE: per line, href=1 for H_ACTIVE*BPP ticks, then href=0 for H_BLANK*BPP ticks. After V_ACTIVE lines, go to VFRONT.
- VFRONT: V_FRONT*L ticks, then pulse frame_done and increment the frame counter.
  - Frame counter equals a nonzero latched frames value, or enable=0: go to IDLE, busy=0.
  - Otherwise: vsync=1, go to VSYNC.

Data:
- data=0 whenever href=0.
- Byte counter: resets to 0 on the href-rising tick, +1 per tick, 8-bit wrap. The first byte of every line is 0x00.
- Mode 0: data = byte counter.
- Mode 1: data = CONST_VAL.
- Mode 2: bar = (pixel*8)/H_ACTIVE (0..7); data = bar*8'h24. All BPP bytes of a pixel carry the same value.
- Mode 3: data = active line index [7:0], constant across the line.

Boundary conditions:
- mode and frames are re-latched only at IDLE->VSYNC and at each VSYNC entry. Mid-frame changes are ignored.
- enable falling mid-frame: the current frame completes and then the FSM stops. No truncated frames.
- enable held high with frames=0: continuous frames, no gap cycles between VFRONT and VSYNC.
- Reset mid-line: all outputs return to reset values immediately (asynchronous). After release, the first vsync occurs on the first fall tick with enable=1.
- Counter widths sized with clog2 of the maximum count; no overflow at the default parameters.

Optional Feature:
Macro CAM_GEN_SHORTLINE_EN.
- Defined:
  - Adds input inj_short (1 bit).
  - A rising edge of inj_short, synchronised to inclk, arms a one-shot.
  - The next line to start href is shortened by one pixel (BPP ticks). The freed ticks are added to that line's blanking, so L is unchanged.
  - Output short_done pulses for one inclk cycle when the shortened line ends. The one-shot is then cleared.
- Undefined: no extra ports, every line is full length, and logic is identical to the base block.

Test Plan:
- Small geometry (H_ACTIVE=4, H_BLANK=2, BPP=2, V_SYNC=1, V_BACK=1, V_ACTIVE=3, V_FRONT=1, PCLK_DIV=2), mode 0, frames=1, enable=1 -> vsync high 12 pclk periods; 3 href pulses of 8 periods separated by 4; data per line 00..07; one frame_done; busy falls; FSM in IDLE.
- Default geometry, mode 0, frames=2 -> per frame exactly 480 href pulses of 1280 pclk periods each, 288-period gaps; 2 frame_done pulses; no third vsync.
- Small geometry, mode 2, H_ACTIVE=8 -> line bytes 00,00,24,24,48,48,…,FC,FC.
- Mode 3, frames=0, enable dropped mid line 2 -> line 2 and remaining lines complete; data equals line index 0,1,2; FSM stops after frame_done.
- res_n asserted mid-href -> href, vsync and data go to 0 the same inclk cycle and pclk=1; after release with enable=1, a new frame starts with vsync.
- CAM_GEN_SHORTLINE_EN defined, inj_short pulsed during VBACK -> first active line href lasts (H_ACTIVE-1)*BPP periods with line total unchanged; short_done pulses once.
